// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: op codes and FSM states.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } muldiv_op_t;

   typedef logic [1:0] muldiv_state_t;

   localparam muldiv_state_t ST_IDLE = 2'd0;
   localparam muldiv_state_t ST_CALC = 2'd1;
   localparam muldiv_state_t ST_FIX  = 2'd2;

   // True for the ops that run through the iterative datapath.
   function automatic logic is_arith_op(input logic [2:0] op);
      return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
   endfunction

   // True for the signed variants, whose operands are converted to magnitudes.
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MULT) || (op == DIV);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bus between the execute-stage controller and the mul/div unit.
interface muldiv_if
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic                            start;
   logic [$bits(muldiv_op_t)-1:0]   op;
   logic [WIDTH-1:0]                a;
   logic [WIDTH-1:0]                b;
   logic                            flush;
   logic                            busy;
   logic                            done;
   logic [WIDTH-1:0]                hi;
   logic [WIDTH-1:0]                lo;

   modport master (output start, op, a, b, flush, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_d_en_reg.sv
// Plain enabled register with asynchronous clear, used for HI and LO.
module d_en_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   // Load on enable, clear on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)     q_o <= '0;
      else if (en_i) q_o <= d_i;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Fixed WIDTH-cycle CALC phase
// followed by one FIX cycle for sign correction and the register write.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic   clock,
   input  logic   reset,
   muldiv_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   muldiv_state_t        state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_res_q, neg_res_d;
   logic                 neg_rem_q, neg_rem_d;
   logic                 dz_q, dz_d;
   logic [WIDTH-1:0]     a_raw_q, a_raw_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic                 done_q, done_d;

   logic                 hi_en, lo_en;
   logic [WIDTH-1:0]     hi_d, lo_d;
   logic [WIDTH-1:0]     res_hi, res_lo;

   logic                 sgn_op;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   prod_fix;

   // Operand magnitudes and per-iteration arithmetic.
   always_comb begin
      sgn_op    = is_signed_op(bus.op);
      mag_a     = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      mag_b     = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});
      div_shift = {rem_q, acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      prod_fix  = neg_res_q ? -acc_q : acc_q;
   end

   // Sign-corrected final result, with the divide-by-zero override.
   always_comb begin
      res_hi = '0;
      res_lo = '0;
      if (!is_div_q) begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end else if (dz_q) begin
         res_hi = a_raw_q;
         res_lo = '1;
      end else begin
         res_hi = neg_rem_q ? -rem_q : rem_q;
         res_lo = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
   end

   // FSM, datapath next state and HI/LO write enables.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      a_raw_d   = a_raw_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      done_d    = 1'b0;
      hi_en     = 1'b0;
      lo_en     = 1'b0;
      hi_d      = bus.a;
      lo_d      = bus.a;

      if (bus.flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start && is_arith_op(bus.op)) begin
                  state_d   = ST_CALC;
                  cnt_d     = '0;
                  is_div_d  = (bus.op == DIV) || (bus.op == DIVU);
                  neg_res_d = sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  neg_rem_d = sgn_op && bus.a[WIDTH-1];
                  dz_d      = ((bus.op == DIV) || (bus.op == DIVU)) && (bus.b == '0);
                  a_raw_d   = bus.a;
                  opnd_d    = mag_b;
                  acc_d     = {{WIDTH{1'b0}}, mag_a};
                  rem_d     = '0;
               end else if (bus.start && (bus.op == MTHI)) begin
                  hi_en = 1'b1;
               end else if (bus.start && (bus.op == MTLO)) begin
                  lo_en = 1'b1;
               end
            end
            ST_CALC: begin
               if (!is_div_q) begin
                  acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               end else if (!div_diff[WIDTH]) begin
                  rem_d = div_diff[WIDTH-1:0];
                  acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = div_shift[WIDTH-1:0];
                  acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               hi_en   = 1'b1;
               lo_en   = 1'b1;
               hi_d    = res_hi;
               lo_d    = res_lo;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Control and datapath state, all cleared by the asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         a_raw_q   <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         a_raw_q   <= a_raw_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         done_q    <= done_d;
      end
   end

   d_en_reg #(.WIDTH(WIDTH)) u_hi (
      .clock (clock),
      .reset (reset),
      .en_i  (hi_en),
      .d_i   (hi_d),
      .q_o   (bus.hi)
   );

   d_en_reg #(.WIDTH(WIDTH)) u_lo (
      .clock (clock),
      .reset (reset),
      .en_i  (lo_en),
      .d_i   (lo_d),
      .q_o   (bus.lo)
   );

   assign bus.busy = (state_q != ST_IDLE);
   assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pushed at issue, popped on done.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic [63:0] exp_q[$];

   muldiv_if #(.WIDTH(32)) mif ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (mif)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result {hi,lo} computed with native wide arithmetic.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb, sq, sr;
      logic [63:0] u;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      u  = '0;
      case (op)
         MULT:  u = sa * sb;
         MULTU: u = {32'b0, a} * {32'b0, b};
         DIV: begin
            if (b == 0) u = {a, 32'hFFFF_FFFF};
            else begin
               sq = sa / sb;
               sr = sa % sb;
               u  = {sr[31:0], sq[31:0]};
            end
         end
         DIVU: begin
            if (b == 0) u = {a, 32'hFFFF_FFFF};
            else u = {a % b, a / b};
         end
         default: u = '0;
      endcase
      return u;
   endfunction

   // Result monitor: every done must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (!reset && mif.done) begin
         if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
         else chk("result_hilo", {mif.hi, mif.lo}, exp_q.pop_front());
      end
   end

   // Issue one op at a negedge, wait for done, check latency and busy length.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit interfere);
      int cyc;
      int bcnt;
      logic got;
      exp_q.push_back(model(op, a, b));
      mif.op    = op;
      mif.a     = a;
      mif.b     = b;
      mif.start = 1'b1;
      @(negedge clock);
      mif.start = 1'b0;
      cyc  = 1;
      bcnt = mif.busy ? 1 : 0;
      got  = mif.done;
      while (!got && cyc < 60) begin
         if (interfere && cyc == 5) begin
            mif.start = 1'b1;
            mif.op    = DIVU;
            mif.a     = 32'h0BAD_F00D;
            mif.b     = 32'h3;
         end else begin
            mif.start = 1'b0;
         end
         @(negedge clock);
         cyc++;
         if (mif.busy) bcnt++;
         got = mif.done;
      end
      mif.start = 1'b0;
      chk("latency", 64'(cyc), 64'd34);
      chk("busy_cycles", 64'(bcnt), 64'd33);
   endtask

   initial begin
      logic [31:0] hold_hi, hold_lo;
      mif.start = 1'b0;
      mif.op    = MULT;
      mif.a     = '0;
      mif.b     = '0;
      mif.flush = 1'b0;

      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("reset_busy", 64'(mif.busy), 64'd0);
      chk("reset_done", 64'(mif.done), 64'd0);
      chk("reset_hilo", {mif.hi, mif.lo}, 64'd0);

      run_op(MULT,  32'hFFFF_FFFD, 32'd5,         1'b0);
      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(DIV,   32'hFFFF_FFF9, 32'd2,         1'b0);
      run_op(DIVU,  32'hFFFF_FFF9, 32'd2,         1'b0);
      run_op(DIVU,  32'd100,       32'd0,         1'b0);
      run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(DIV,   32'hFFFF_FF00, 32'd0,         1'b0);
      run_op(DIV,   32'd17,        32'hFFFF_FFFB, 1'b0);
      for (int i = 0; i < 6; i++) begin
         run_op(3'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'd0 : $urandom, 1'b0);
      end

      // Start pulse mid-operation must be ignored.
      run_op(MULTU, 32'h0001_0003, 32'h0000_0101, 1'b1);
      @(negedge clock);

      // MTHI / MTLO write directly, no busy, no done.
      mif.op = MTHI; mif.a = 32'h1234; mif.start = 1'b1;
      @(posedge clock); #1;
      chk("mthi_hi", 64'(mif.hi), 64'h1234);
      chk("mthi_busy", 64'(mif.busy), 64'd0);
      @(negedge clock);
      mif.op = MTLO; mif.a = 32'h5678;
      @(posedge clock); #1;
      chk("mtlo_lo", 64'(mif.lo), 64'h5678);
      chk("mtlo_hi_kept", 64'(mif.hi), 64'h1234);
      @(negedge clock);
      mif.start = 1'b0;

      // Undefined op code is ignored.
      mif.op = 3'd7; mif.a = 32'hDEAD; mif.start = 1'b1;
      @(negedge clock);
      mif.start = 1'b0;
      chk("undef_busy", 64'(mif.busy), 64'd0);
      chk("undef_hilo", {mif.hi, mif.lo}, {32'h1234, 32'h5678});

      // Flush at cycle 10 of a divide.
      hold_hi = mif.hi; hold_lo = mif.lo;
      mif.op = DIV; mif.a = 32'd1000; mif.b = 32'd7; mif.start = 1'b1;
      @(negedge clock);
      mif.start = 1'b0;
      repeat (9) @(negedge clock);
      mif.flush = 1'b1;
      @(posedge clock); #1;
      chk("flush_busy", 64'(mif.busy), 64'd0);
      @(negedge clock);
      mif.flush = 1'b0;
      repeat (40) @(negedge clock);
      chk("flush_hilo", {mif.hi, mif.lo}, {hold_hi, hold_lo});

      // Flush in the FIX cycle suppresses the write.
      mif.op = MULTU; mif.a = 32'd9; mif.b = 32'd9; mif.start = 1'b1;
      @(negedge clock);
      mif.start = 1'b0;
      repeat (32) @(negedge clock);
      chk("fix_cycle_busy", 64'(mif.busy), 64'd1);
      mif.flush = 1'b1;
      @(negedge clock);
      mif.flush = 1'b0;
      chk("fixflush_done", 64'(mif.done), 64'd0);
      chk("fixflush_busy", 64'(mif.busy), 64'd0);
      chk("fixflush_hilo", {mif.hi, mif.lo}, {hold_hi, hold_lo});

      // Asynchronous reset mid-CALC.
      mif.op = MULTU; mif.a = 32'hFFFF; mif.b = 32'hFFFF; mif.start = 1'b1;
      @(negedge clock);
      mif.start = 1'b0;
      repeat (10) @(negedge clock);
      #3;
      reset = 1'b1;
      #1;
      chk("areset_busy", 64'(mif.busy), 64'd0);
      chk("areset_done", 64'(mif.done), 64'd0);
      chk("areset_hilo", {mif.hi, mif.lo}, 64'd0);
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_op(MULT, 32'd6, 32'd7, 1'b0);
      chk("post_reset_mult", {mif.hi, mif.lo}, 64'd42);

      repeat (5) @(negedge clock);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit owning the HI/LO special-purpose registers. Replaces the single-cycle combinational MULT/DIV path.
- Sits beside the ALU in the execute stage. The controller issues an op with a start pulse and stalls on busy. MFHI/MFLO read hi/lo directly.
- Parametrised in width. Adds signed/unsigned modes, MTHI/MTLO, flush, and defined divide-by-zero results.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
start  input  1  issue op this cycle; honoured only while busy=0
op  input  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
a  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
b  input  WIDTH  multiplier / divisor
flush  input  1  synchronous abort of in-flight op
busy  output  1  op in progress; controller must stall MF*/MUL*/DIV*
done  output  1  one-cycle pulse when hi/lo updated by MULT/DIV family
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, hi=0, lo=0; internal accumulators cleared. An in-flight op is discarded.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}, at edge k:
  - Latch magnitudes of a and b (two's-complement negate if signed op and MSB set).
  - Latch result sign flags and the divide-by-zero flag. Clear the iteration counter.
  - Go to CALC; busy=1 from cycle k+1.
- IDLE, start=1, op=MTHI / MTLO: at edge k, hi<=a / lo<=a. No busy, no done.
- Undefined op codes: ignored.
- CALC: one iteration per cycle for exactly WIDTH cycles.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. Partial remainder is WIDTH+1 bits. Quotient bits shift into the low word.
  - After the WIDTH-th iteration, go to FIX.
- FIX (one cycle):
  - Apply sign correction. Signed product is negated if signs differ. Quotient is negated if signs differ. Remainder takes the sign of the dividend.
  - At the FIX edge, write hi/lo, go to IDLE, set busy=0 and done=1 for exactly one cycle.
- Fixed latency: start at edge k -> done high and hi/lo valid in the cycle after edge k+WIDTH+1. This holds for every MULT/DIV op, including divide-by-zero.
- Divide by zero (b=0): lo = all ones, hi = a (original, unsigned-interpreted bits). The CALC cycles still elapse.
- Signed overflow DIV MIN / -1: lo = MIN (0x80000000 at WIDTH=32), hi = 0. This falls out naturally from the magnitude path.
- start while busy=1: ignored entirely; no queueing.
- flush=1 (any state, synchronous):
  - Return to IDLE next edge, busy=0.
  - hi/lo keep pre-op values; no done pulse.
  - flush overrides a simultaneous start.
- flush in the FIX cycle wins: no write.
- done and start may coincide: new op is accepted in the cycle done is high, since busy=0 then.
- hi/lo change only at a FIX edge, an MTHI/MTLO edge, or reset.

Decomposition:
- global_types gets:
  - muldiv_op_t (3-bit enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5).
  - muldiv_state_t (IDLE, CALC, FIX).
- HI and LO are two d_en_reg #(WIDTH) instances. Enable is the FIX write or the matching MT* write.
- The datapath and FSM stay in one module; no further sub-module.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> done exactly 34 cycles after start edge; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=1.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x64, same latency. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Control:
  - MTHI a=0x1234 then MFHI-visible hi=0x1234 next cycle, no done.
  - Start DIV, assert flush at cycle 10 -> busy drops next cycle, hi/lo unchanged, no done.
  - Pulse start again at cycle 5 of an op -> ignored, result matches first op.
- Assert reset asynchronously mid-CALC (not clock-aligned) -> busy/done/hi/lo go 0 immediately. A new MULT 6*7 after release -> lo=42, hi=0.
